amba3_axi2apb_bridge: RTL

- Synthesizable AXI3 slave to APB3 master bridge; feeds the APB slave side of the AMBA3 environment from an AXI master.
- Converts each AXI beat into one APB transfer (SETUP+ACCESS). Supports FIXED/INCR/WRAP bursts and 32-bit beats. One transaction outstanding at a time; reads and writes arbitrated alternately.

---
 rtl/amba3_axi2apb_bridge_pkg.sv | 33 +++
 rtl/amba3_axi2apb_bridge_if.sv | 71 +++++++
 rtl/amba3_axi2apb_addr_gen.sv | 33 +++
 rtl/amba3_axi2apb_bridge.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/amba3_axi2apb_bridge_pkg.sv
// Shared types for the AXI3-to-APB3 bridge.
//   burst_type_t   : AXI burst encodings (FIXED/INCR/WRAP/reserved)
//   resp_type_t    : AXI response encodings
//   bridge_state_t : bridge sequencing states
//   WORD_BYTES     : bytes per beat (32-bit data path)
package amba3_axi2apb_bridge_pkg;

    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_type_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_type_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_SETUP,
        ST_ACCESS,
        ST_BRESP,
        ST_RDATA
    } bridge_state_t;

endpackage

// File: rtl/amba3_axi2apb_bridge_if.sv
// Bus bundle between an AXI3 master, the bridge and an APB3 slave.
//   slave  modport : the bridge's view (AXI slave side + APB master side)
//   master modport : the environment's view (AXI master + APB slave completion)
// Signals: AW/W/B/AR/R channels (no wid), APB paddr/psel/penable/pwrite/pwdata,
// prdata/pready/pslverr.
interface amba3_axi2apb_bridge_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned ID_W   = 4
);
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [3:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [3:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;
    logic [ID_W-1:0]   rid;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;
    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        input  rready,
        input  prdata, pready, pslverr,
        output awready, wready, bid, bresp, bvalid, arready,
        output rid, rdata, rresp, rlast, rvalid,
        output paddr, psel, penable, pwrite, pwdata
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        output rready,
        output prdata, pready, pslverr,
        input  awready, wready, bid, bresp, bvalid, arready,
        input  rid, rdata, rresp, rlast, rvalid,
        input  paddr, psel, penable, pwrite, pwdata
    );
endinterface

// File: rtl/amba3_axi2apb_addr_gen.sv
// Next-beat address for an AXI burst.
//   addr      : current word-aligned beat address
//   len       : burst length minus one
//   burst     : burst type
//   next_addr : address of the following beat
// WRAP with len other than 1/3/7/15 advances like INCR.
module amba3_axi2apb_addr_gen
    import amba3_axi2apb_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        len,
    input  burst_type_t       burst,
    output logic [ADDR_W-1:0] next_addr
);
    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] mask;
    logic              wrap_ok;

    always_comb begin
        incr      = addr + ADDR_W'(WORD_BYTES);
        // Wrap window is (len+1)*4 bytes; mask selects the offset inside it.
        mask      = ADDR_W'({len, 2'b11});
        wrap_ok   = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
        next_addr = incr;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  if (wrap_ok) next_addr = (addr & ~mask) | (incr & mask);
            default:     next_addr = incr;
        endcase
    end
endmodule

// File: rtl/amba3_axi2apb_bridge.sv
// AXI3 slave to APB3 master bridge: one APB SETUP+ACCESS transfer per AXI beat,
// one transaction outstanding, reads and writes alternate under contention.
//   aclk   : clock for both sides
//   areset : asynchronous active-high reset
//   bus    : AXI channels + APB request/completion (slave modport)
// Optional: define AMBA3_AXI2APB_TIMEOUT_EN to bound ACCESS to TIMEOUT cycles;
// a timed-out transfer completes with SLVERR (and zero read data).
module amba3_axi2apb_bridge
    import amba3_axi2apb_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned ID_W    = 4,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic                 aclk,
    input  logic                 areset,
    amba3_axi2apb_bridge_if.slave bus
);
    bridge_state_t     state;
    logic              prio_w;
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] next_addr;
    logic [3:0]        len;
    logic [3:0]        beats_left;
    burst_type_t       burst;
    logic              err;
    logic              rsvd;
    logic              aw_hs;
    logic              ar_hs;
    logic              access_done;
    logic              slverr_eff;
    logic [31:0]       rdata_eff;

    assign bus.awready = (state == ST_IDLE) & (prio_w | ~bus.arvalid);
    assign bus.arready = (state == ST_IDLE) & ~(bus.awvalid & bus.awready);
    assign bus.wready  = (state == ST_WDATA);
    assign aw_hs       = bus.awvalid & bus.awready;
    assign ar_hs       = bus.arvalid & bus.arready;
    assign rsvd        = (burst == BURST_RSVD);

    amba3_axi2apb_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .addr      (addr),
        .len       (len),
        .burst     (burst),
        .next_addr (next_addr)
    );

`ifdef AMBA3_AXI2APB_TIMEOUT_EN
    localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);
    logic [TCNT_W-1:0] tcnt;
    logic              timed_out;

    assign timed_out   = (state == ST_ACCESS) && !bus.pready && (tcnt == TCNT_W'(TIMEOUT - 1));
    assign access_done = bus.pready | timed_out;
    assign slverr_eff  = bus.pslverr | timed_out;
    assign rdata_eff   = timed_out ? '0 : bus.prdata;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) tcnt <= '0;
        else if (state == ST_ACCESS && !access_done) tcnt <= tcnt + 1'b1;
        else tcnt <= '0;
    end
`else
    assign access_done = bus.pready;
    assign slverr_eff  = bus.pslverr;
    assign rdata_eff   = bus.prdata;
`endif

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state       <= ST_IDLE;
            prio_w      <= 1'b1;
            id          <= '0;
            addr        <= '0;
            len         <= '0;
            burst       <= BURST_FIXED;
            beats_left  <= '0;
            err         <= 1'b0;
            bus.paddr   <= '0;
            bus.psel    <= 1'b0;
            bus.penable <= 1'b0;
            bus.pwrite  <= 1'b0;
            bus.pwdata  <= '0;
            bus.bid     <= '0;
            bus.bresp   <= RESP_OKAY;
            bus.bvalid  <= 1'b0;
            bus.rid     <= '0;
            bus.rdata   <= '0;
            bus.rresp   <= RESP_OKAY;
            bus.rlast   <= 1'b0;
            bus.rvalid  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (aw_hs) begin
                        id         <= bus.awid;
                        addr       <= {bus.awaddr[ADDR_W-1:2], 2'b00};
                        len        <= bus.awlen;
                        burst      <= burst_type_t'(bus.awburst);
                        beats_left <= bus.awlen;
                        err        <= 1'b0;
                        prio_w     <= ~prio_w;
                        bus.pwrite <= 1'b1;
                        state      <= ST_WDATA;
                    end else if (ar_hs) begin
                        id         <= bus.arid;
                        addr       <= {bus.araddr[ADDR_W-1:2], 2'b00};
                        len        <= bus.arlen;
                        burst      <= burst_type_t'(bus.arburst);
                        beats_left <= bus.arlen;
                        prio_w     <= ~prio_w;
                        bus.pwrite <= 1'b0;
                        if (burst_type_t'(bus.arburst) == BURST_RSVD) begin
                            // Reserved burst: answer every beat with SLVERR, no APB access.
                            bus.rid    <= bus.arid;
                            bus.rdata  <= '0;
                            bus.rresp  <= RESP_SLVERR;
                            bus.rlast  <= (bus.arlen == 4'd0);
                            bus.rvalid <= 1'b1;
                            state      <= ST_RDATA;
                        end else begin
                            bus.paddr <= {bus.araddr[ADDR_W-1:2], 2'b00};
                            bus.psel  <= 1'b1;
                            state     <= ST_SETUP;
                        end
                    end
                end
                ST_WDATA: begin
                    if (bus.wvalid) begin
                        if (rsvd || bus.wstrb == 4'b0000) begin
                            // Beat consumed without an APB transfer.
                            addr <= next_addr;
                            if (rsvd) err <= 1'b1;
                            if (beats_left == 4'd0) begin
                                bus.bid    <= id;
                                bus.bresp  <= (err || rsvd) ? RESP_SLVERR : RESP_OKAY;
                                bus.bvalid <= 1'b1;
                                state      <= ST_BRESP;
                            end else begin
                                beats_left <= beats_left - 4'd1;
                            end
                        end else begin
                            bus.paddr  <= addr;
                            bus.pwdata <= bus.wdata;
                            bus.psel   <= 1'b1;
                            state      <= ST_SETUP;
                        end
                    end
                end
                ST_SETUP: begin
                    bus.penable <= 1'b1;
                    state       <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (access_done) begin
                        bus.psel    <= 1'b0;
                        bus.penable <= 1'b0;
                        addr        <= next_addr;
                        if (bus.pwrite) begin
                            err <= err | slverr_eff;
                            if (beats_left == 4'd0) begin
                                bus.bid    <= id;
                                bus.bresp  <= (err || slverr_eff) ? RESP_SLVERR : RESP_OKAY;
                                bus.bvalid <= 1'b1;
                                state      <= ST_BRESP;
                            end else begin
                                beats_left <= beats_left - 4'd1;
                                state      <= ST_WDATA;
                            end
                        end else begin
                            bus.rid    <= id;
                            bus.rdata  <= rdata_eff;
                            bus.rresp  <= slverr_eff ? RESP_SLVERR : RESP_OKAY;
                            bus.rlast  <= (beats_left == 4'd0);
                            bus.rvalid <= 1'b1;
                            state      <= ST_RDATA;
                        end
                    end
                end
                ST_RDATA: begin
                    if (bus.rready) begin
                        bus.rvalid <= 1'b0;
                        bus.rlast  <= 1'b0;
                        if (beats_left == 4'd0) begin
                            state <= ST_IDLE;
                        end else begin
                            beats_left <= beats_left - 4'd1;
                            if (rsvd) begin
                                bus.rvalid <= 1'b1;
                                bus.rlast  <= (beats_left == 4'd1);
                            end else begin
                                bus.paddr <= addr;
                                bus.psel  <= 1'b1;
                                state     <= ST_SETUP;
                            end
                        end
                    end
                end
                ST_BRESP: begin
                    if (bus.bready) begin
                        bus.bvalid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
